// File: rtl/vga_capture.sv
`default_nettype none
// ============================================================================
//  Module      : vga_capture
//  Description : VGA stream receiver. Registers the display-path sync, blank
//                and RGB signals, recovers pixel coordinates, checks the line
//                and frame periods, tracks timing lock and decodes the 5x5
//                game board from the centre pixel of every rendered cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_capture #(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int GRID_X0 = 160,
    parameter int GRID_Y0 = 80,
    parameter int CELL    = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hsync,
    input  logic                   vsync,
    input  logic                   blank_b,
    input  logic [7:0]             r,
    input  logic [7:0]             g,
    input  logic [7:0]             b,
    output logic [9:0]             x,
    output logic [9:0]             y,
    output logic                   active,
    output logic                   h_err,
    output logic                   v_err,
    output logic                   locked,
    output logic                   frame_done,
    output logic [7:0]             frame_count,
    output logic [4:0][4:0][1:0]   board
);

    localparam logic [9:0] c_h_last = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_v_last = 10'(V_TOTAL - 1);
    localparam logic [1:0] c_good_max = 2'd2;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        bl;
        logic [23:0] rgb;
    } vid_t;

    vid_t s1_q, s1_d, s2_q, s2_d;

    logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic       h_seen_q, h_seen_d, v_seen_q, v_seen_d, v_pend_q, v_pend_d;
    logic       ev_h_err_q, ev_h_err_d, ev_v_err_q, ev_v_err_d, ev_fend_q, ev_fend_d;

    logic [9:0] x_q, x_d, y_q, y_d;
    logic       active_q, active_d;

    logic [4:0][4:0][1:0] shadow_q, shadow_d, board_q, board_d;
    logic [24:0]          mask_q, mask_d;

    logic       h_err_q, h_err_d, v_err_q, v_err_d, frame_done_q, frame_done_d;
    logic       frame_err_q, frame_err_d, locked_q, locked_d;
    logic [1:0] good_q, good_d;
    logic [7:0] frame_count_q, frame_count_d;

    logic w_h_fall, w_v_fall, w_a_rise, w_a_fall, w_boundary, w_any_err;

    assign w_h_fall   = s2_q.hs & ~s1_q.hs;
    assign w_v_fall   = s2_q.vs & ~s1_q.vs;
    assign w_a_rise   = s1_q.bl & ~s2_q.bl;
    assign w_a_fall   = s2_q.bl & ~s1_q.bl;
    assign w_boundary = w_h_fall & v_pend_q;
    assign w_any_err  = ev_h_err_q | ev_v_err_q;

    // Map the colour MSBs of a cell-centre pixel back to a cell state
    function automatic logic [1:0] decode(input logic [23:0] rgb);
        logic [2:0] msb;
        msb = {rgb[23], rgb[15], rgb[7]};
        case (msb)
            3'b100:  decode = 2'b10;
            3'b010:  decode = 2'b11;
            3'b001:  decode = 2'b01;
            default: decode = 2'b00;
        endcase
    endfunction

    // Input stage: s1 captures the pins, s2 keeps the previous sample for edges
    always_comb begin
        s1_d = '{hs: hsync, vs: vsync, bl: blank_b, rgb: {r, g, b}};
        s2_d = s1_q;
    end

    // Line/frame period measurement; errors and frame end are raised as events
    always_comb begin
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        h_seen_d   = h_seen_q;
        v_seen_d   = v_seen_q;
        v_pend_d   = v_pend_q | w_v_fall;
        ev_h_err_d = 1'b0;
        ev_v_err_d = 1'b0;
        ev_fend_d  = 1'b0;
        if (w_h_fall) begin
            hcnt_d   = 10'd0;
            h_seen_d = 1'b1;
            ev_h_err_d = h_seen_q && (hcnt_q != c_h_last);
            if (v_pend_q) begin
                // A v_fall coinciding with this boundary is dropped here
                ev_fend_d  = 1'b1;
                ev_v_err_d = v_seen_q && (vcnt_q != c_v_last);
                v_seen_d   = 1'b1;
                v_pend_d   = 1'b0;
                vcnt_d     = 10'd0;
            end else begin
                vcnt_d = vcnt_q + 10'd1;
            end
        end else if (hcnt_q != 10'h3FF) begin
            hcnt_d = hcnt_q + 10'd1;
        end
    end

    // Coordinate recovery from the blank edges; values hold through blanking
    always_comb begin
        active_d = s1_q.bl;
        x_d      = x_q;
        y_d      = y_q;
        if (w_a_rise) begin
            x_d = 10'd0;
        end else if (s1_q.bl) begin
            x_d = x_q + 10'd1;
        end
        if (w_boundary) begin
            y_d = 10'd0;
        end else if (w_a_fall) begin
            y_d = y_q + 10'd1;
        end
    end

    // Cell-centre sampling: x/y describe the pixel now held in s2
    always_comb begin
        shadow_d = shadow_q;
        mask_d   = mask_q;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                if (active_q &&
                    x_q == 10'(GRID_X0 + j * CELL + CELL / 2) &&
                    y_q == 10'(GRID_Y0 + i * CELL + CELL / 2)) begin
                    shadow_d[i][j]  = decode(s2_q.rgb);
                    mask_d[i*5 + j] = 1'b1;
                end
            end
        end
        if (ev_fend_q) begin
            mask_d = '0;
        end
    end

    // Frame end: publish the board, count frames and track lock
    always_comb begin
        h_err_d       = ev_h_err_q;
        v_err_d       = ev_v_err_q;
        frame_done_d  = ev_fend_q;
        frame_err_d   = frame_err_q | w_any_err;
        board_d       = board_q;
        frame_count_d = frame_count_q;
        good_d        = good_q;
        if (ev_fend_q) begin
            frame_err_d = 1'b0;
            if ((&mask_q) && !frame_err_q && !w_any_err) begin
                board_d       = shadow_q;
                frame_count_d = frame_count_q + 8'd1;
            end
        end
        if (w_any_err) begin
            good_d = 2'd0;
        end else if (ev_fend_q && !frame_err_q && good_q != c_good_max) begin
            good_d = good_q + 2'd1;
        end
        locked_d = (good_d == c_good_max);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q          <= '0;
            s2_q          <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            h_seen_q      <= 1'b0;
            v_seen_q      <= 1'b0;
            v_pend_q      <= 1'b0;
            ev_h_err_q    <= 1'b0;
            ev_v_err_q    <= 1'b0;
            ev_fend_q     <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            active_q      <= 1'b0;
            shadow_q      <= '0;
            mask_q        <= '0;
            board_q       <= '0;
            h_err_q       <= 1'b0;
            v_err_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            good_q        <= '0;
            locked_q      <= 1'b0;
            frame_count_q <= '0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            h_seen_q      <= h_seen_d;
            v_seen_q      <= v_seen_d;
            v_pend_q      <= v_pend_d;
            ev_h_err_q    <= ev_h_err_d;
            ev_v_err_q    <= ev_v_err_d;
            ev_fend_q     <= ev_fend_d;
            x_q           <= x_d;
            y_q           <= y_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            mask_q        <= mask_d;
            board_q       <= board_d;
            h_err_q       <= h_err_d;
            v_err_q       <= v_err_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
            good_q        <= good_d;
            locked_q      <= locked_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign active      = active_q;
    assign h_err       = h_err_q;
    assign v_err       = v_err_q;
    assign locked      = locked_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign board       = board_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_capture
//  Description : Directed bench for vga_capture on a reduced raster
//                (32x28 total, 24x22 active, 4-pixel cells) so a dozen frames
//                fit in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_capture;

    localparam int H_TOT = 32;
    localparam int V_TOT = 28;
    localparam int H_ACT = 24;
    localparam int V_ACT = 22;
    localparam int N_FD  = 14;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 hsync, vsync, blank_b;
    logic [7:0]           r, g, b;
    logic [9:0]           x, y;
    logic                 active, h_err, v_err, locked, frame_done;
    logic [7:0]           frame_count;
    logic [4:0][4:0][1:0] board;

    vga_capture #(
        .H_TOTAL(H_TOT), .V_TOTAL(V_TOT), .GRID_X0(2), .GRID_Y0(1), .CELL(4)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .blank_b(blank_b),
        .r(r), .g(g), .b(b), .x(x), .y(y), .active(active), .h_err(h_err),
        .v_err(v_err), .locked(locked), .frame_done(frame_done),
        .frame_count(frame_count), .board(board)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Capture pulse counts and state at every frame_done
    int        n_herr = 0, n_verr = 0, n_fd = 0;
    logic      fd_lock  [N_FD];
    logic [7:0] fd_fc   [N_FD];
    logic [49:0] fd_board [N_FD];
    int        fd_herr  [N_FD];
    int        fd_verr  [N_FD];

    always @(posedge clk) begin
        #2;
        if (h_err) n_herr++;
        if (v_err) n_verr++;
        if (frame_done) begin
            if (n_fd < N_FD) begin
                fd_lock[n_fd]  = locked;
                fd_fc[n_fd]    = frame_count;
                fd_board[n_fd] = board;
                fd_herr[n_fd]  = n_herr;
                fd_verr[n_fd]  = n_verr;
            end
            n_fd++;
        end
    end

    // Pixel pipeline so outputs can be matched to the pixel driven two cycles earlier
    int p1_ln = -1, p1_col = -1, p2_ln = -1, p2_col = -1;
    bit p1_chk = 0, p2_chk = 0, rst_pend = 0;

    function automatic logic [23:0] pix_rgb(input int ln, input int col, input bit pat);
        if (!pat) return 24'h000000;
        if (col == 16 && ln == 11) return 24'hFF0000;   // cell (2,3) -> hit
        if (col == 4  && ln == 3)  return 24'h0000FF;   // cell (0,0) -> ship
        if (col == 20 && ln == 19) return 24'h00FF00;   // cell (4,4) -> miss
        return 24'h000000;
    endfunction

    task automatic drive_pix(input int ln, input int col, input bit pat,
                             input bit do_rst, input bit cchk);
        logic act;
        logic [23:0] rgb;
        @(negedge clk);
        if (rst_pend) begin
            chk("rst_ctl", {x, y, active, h_err, v_err, locked, frame_done, frame_count}, 64'd0);
            chk("rst_board", board, 64'd0);
            rst_pend = 0;
        end
        if (p2_chk) begin
            if (p2_ln == 0 && p2_col == 0)
                chk("first_xy", {active, x, y}, {1'b1, 10'd0, 10'd0});
            if (p2_ln == 5 && p2_col == H_ACT - 1)
                chk("last_x", {active, x}, {1'b1, 10'd23});
            if (p2_ln == 5 && p2_col == H_ACT)
                chk("blank_hold_x", {active, x}, {1'b0, 10'd23});
            if (p2_ln == V_ACT - 1 && p2_col == 0)
                chk("last_y", {active, y}, {1'b1, 10'd21});
        end
        p2_ln = p1_ln; p2_col = p1_col; p2_chk = p1_chk;
        p1_ln = ln;    p1_col = col;    p1_chk = cchk;
        act     = (ln < V_ACT) && (col < H_ACT);
        rgb     = act ? pix_rgb(ln, col, pat) : 24'h000000;
        hsync   = !(col >= 26 && col < 30);
        vsync   = !(ln == 24 || ln == 25);
        blank_b = act;
        {r, g, b} = rgb;
        rst     = do_rst;
        if (do_rst) rst_pend = 1;
    endtask

    task automatic run_frame(input int nlines, input int long_ln, input bit pat,
                             input int rst_ln, input bit cchk);
        int ncol;
        for (int ln = 0; ln < nlines; ln++) begin
            ncol = (ln == long_ln) ? H_TOT + 1 : H_TOT;
            for (int c = 0; c < ncol; c++)
                drive_pix(ln, c, pat, (ln == rst_ln && c == 5), cchk);
        end
    endtask

    // Expected state at each frame_done, worked out by hand from the sequence below
    logic [49:0]          board_pat;
    logic [4:0][4:0][1:0] pat_tmp;
    logic                 exp_lock [N_FD] = '{0,1,1,1,0,0,1,1,0,0,1,0,1,1};
    int                   exp_fc   [N_FD] = '{1,2,3,4,4,5,6,7,7,8,9,0,1,2};
    bit                   exp_pat  [N_FD] = '{0,0,0,1,1,0,0,0,0,0,1,0,0,0};
    int                   exp_herr [N_FD] = '{0,0,0,0,1,1,1,1,1,1,1,1,1,1};
    int                   exp_verr [N_FD] = '{0,0,0,0,0,0,0,0,1,1,1,1,1,1};

    initial begin
        pat_tmp       = '0;
        pat_tmp[0][0] = 2'b01;
        pat_tmp[2][3] = 2'b10;
        pat_tmp[4][4] = 2'b11;
        board_pat     = pat_tmp;

        rst = 1'b1; hsync = 1'b1; vsync = 1'b1; blank_b = 1'b0;
        r = 8'd0; g = 8'd0; b = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", {x, y, active, h_err, v_err, locked, frame_done, frame_count}, 64'd0);
        chk("reset_board", board, 64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        run_frame(V_TOT, -1, 0, -1, 0);   // F1
        run_frame(V_TOT, -1, 0, -1, 1);   // F2 coordinate checks
        run_frame(V_TOT, -1, 0, -1, 1);   // F3 coordinate checks
        run_frame(V_TOT, -1, 1, -1, 0);   // F4 board pattern
        run_frame(V_TOT,  5, 0, -1, 0);   // F5 one 33-clock line
        run_frame(V_TOT, -1, 0, -1, 0);   // F6
        run_frame(V_TOT, -1, 0, -1, 0);   // F7
        run_frame(V_TOT - 2, -1, 0, -1, 0); // F8 short frame
        run_frame(V_TOT, -1, 0, -1, 0);   // F9 early boundary
        run_frame(V_TOT, -1, 0, -1, 0);   // F10
        run_frame(V_TOT, -1, 1, -1, 0);   // F11 pattern again
        run_frame(V_TOT, -1, 0, 10, 0);   // F12 reset mid-line
        run_frame(V_TOT, -1, 0, -1, 0);   // F13
        run_frame(V_TOT, -1, 0, -1, 0);   // F14
        repeat (6) @(negedge clk);

        chk("n_frame_done", n_fd, N_FD);
        for (int i = 0; i < N_FD && i < n_fd; i++) begin
            chk($sformatf("fd%0d_locked", i), fd_lock[i], exp_lock[i]);
            chk($sformatf("fd%0d_count", i), fd_fc[i], exp_fc[i]);
            chk($sformatf("fd%0d_board", i), fd_board[i], exp_pat[i] ? board_pat : 50'd0);
            chk($sformatf("fd%0d_herr_total", i), fd_herr[i], exp_herr[i]);
            chk($sformatf("fd%0d_verr_total", i), fd_verr[i], exp_verr[i]);
        end
        chk("herr_cycles", n_herr, 1);
        chk("verr_cycles", n_verr, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
